// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the npc core: fetch, decode, execute, memory, writeback,
// with illegal-opcode and bus-timeout traps, ebreak halt and a retire counter.
module mc_ctrl #(
    parameter int TIMEOUT = 255,
    parameter bit MDU_EN  = 1'b1,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_inst,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    output logic             lsu_req_we,
    input  logic             lsu_rsp_valid,
    input  logic             exu_done,
    output logic [31:0]      inst_reg,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel_trap,
    output logic             trap_valid,
    output logic [3:0]       trap_cause,
    output logic             halt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH_REQ  = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC       = 4'd4,
        S_MEM_REQ    = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_WB         = 4'd7,
        S_TRAP       = 4'd8,
        S_HALT       = 4'd9
    } state_t;

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_LOAD_FP   = 7'h07;
    localparam logic [6:0] OPC_MISC_MEM  = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_STORE_FP  = 7'h27;
    localparam logic [6:0] OPC_AMO       = 7'h2F;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_MADD      = 7'h43;
    localparam logic [6:0] OPC_MSUB      = 7'h47;
    localparam logic [6:0] OPC_NMSUB     = 7'h4B;
    localparam logic [6:0] OPC_NMADD     = 7'h4F;
    localparam logic [6:0] OPC_OP_FP     = 7'h53;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    localparam int             WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [31:0]        inst_q, inst_d;
    logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [3:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   retire_q, retire_d;

    logic [6:0] opcode;
    logic       op_known, is_mop, illegal, is_ebreak, is_store, is_mem, writes_rd;
    logic       timed_out, in_wait_state;
    logic [3:0] mem_cause;

    assign opcode = inst_q[6:0];

    // Custom and reserved major opcodes fall through to the default and are illegal.
    always_comb begin
        op_known = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_LOAD_FP, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32,
            OPC_STORE, OPC_STORE_FP, OPC_AMO, OPC_OP, OPC_LUI, OPC_OP_32,
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD, OPC_OP_FP,
            OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: op_known = 1'b1;
            default:                                   op_known = 1'b0;
        endcase
    end

    assign is_mop    = ((opcode == OPC_OP) || (opcode == OPC_OP_32)) && (inst_q[31:25] == 7'b0000001);
    assign illegal   = (inst_q[1:0] != 2'b11) || !op_known || (is_mop && !MDU_EN);
    assign is_ebreak = (opcode == OPC_SYSTEM) && (inst_q[31:7] == 25'h0002000);
    assign is_store  = (opcode == OPC_STORE) || (opcode == OPC_STORE_FP);
    assign is_mem    = is_store || (opcode == OPC_LOAD) || (opcode == OPC_LOAD_FP) || (opcode == OPC_AMO);
    assign writes_rd = !(is_store || (opcode == OPC_BRANCH) || (opcode == OPC_MISC_MEM))
                       && (inst_q[11:7] != 5'd0);
    assign mem_cause = is_store ? 4'd7 : 4'd5;
    assign timed_out = (wait_cnt_q == WC_LAST);

    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        cause_d  = cause_q;
        retire_d = retire_q;
        case (state_q)
            S_IDLE:       state_d = S_FETCH_REQ;
            S_FETCH_REQ: begin
                if (ifu_req_ready) begin
                    state_d = S_FETCH_WAIT;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 4'd1;
                end
            end
            S_FETCH_WAIT: begin
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rsp_inst;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 4'd1;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_TRAP;
                    cause_d = 4'd2;
                end else if (is_ebreak) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!(is_mop && MDU_EN) || exu_done) begin
                    state_d = is_mem ? S_MEM_REQ : S_WB;
                end
            end
            S_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_d = S_MEM_WAIT;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = mem_cause;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = S_WB;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = mem_cause;
                end
            end
            S_WB: begin
                retire_d = retire_q + CNT_W'(1);
                state_d  = S_FETCH_REQ;
            end
            S_TRAP:       state_d = S_FETCH_REQ;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_IDLE;
        endcase
    end

    // Any state change restarts the bus wait counter; it only runs while parked in a bus state.
    assign in_wait_state = (state_d == S_FETCH_REQ) || (state_d == S_FETCH_WAIT)
                           || (state_d == S_MEM_REQ) || (state_d == S_MEM_WAIT);
    assign wait_cnt_d    = ((state_d == state_q) && in_wait_state) ? wait_cnt_q + WC_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            inst_q     <= '0;
            wait_cnt_q <= '0;
            cause_q    <= '0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
            retire_q   <= retire_d;
        end
    end

    assign ifu_req_valid = (state_q == S_FETCH_REQ);
    assign lsu_req_valid = (state_q == S_MEM_REQ);
    assign lsu_req_we    = (state_q == S_MEM_REQ) && is_store;
    assign rf_we         = (state_q == S_WB) && writes_rd;
    assign pc_we         = (state_q == S_WB) || (state_q == S_TRAP);
    assign pc_sel_trap   = (state_q == S_TRAP);
    assign trap_valid    = (state_q == S_TRAP);
    assign trap_cause    = cause_q;
    assign halt          = (state_q == S_HALT);
    assign inst_reg      = inst_q;
    assign retire_cnt    = retire_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: scripts each instruction's expected state walk from the
// opcode rules and the bus delays it chooses, and checks outputs every cycle.
module tb_mc_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 64;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FR = 4'd1, ST_FW = 4'd2, ST_DEC = 4'd3,
                           ST_EXEC = 4'd4, ST_MR = 4'd5, ST_MW = 4'd6, ST_WB = 4'd7,
                           ST_TRAP = 4'd8, ST_HALT = 4'd9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0]      ifu_rsp_inst;
    logic             lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid, exu_done;
    logic [31:0]      inst_reg;
    logic             rf_we, pc_we, pc_sel_trap, trap_valid, halt;
    logic [3:0]       trap_cause, state_o;
    logic [CNT_W-1:0] retire_cnt;

    mc_ctrl #(.TIMEOUT(TIMEOUT), .MDU_EN(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_we(lsu_req_we), .lsu_rsp_valid(lsu_rsp_valid), .exu_done(exu_done),
        .inst_reg(inst_reg), .rf_we(rf_we), .pc_we(pc_we), .pc_sel_trap(pc_sel_trap),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .halt(halt),
        .retire_cnt(retire_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] exp_retire;
    bit               cur_st, cur_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Opcode rules: legality, ebreak, memory class, store class, M-op, rd write.
    task automatic classify(input logic [31:0] i, output bit ill, output bit eb, output bit mem,
                            output bit st, output bit mop, output bit wr);
        logic [6:0] opc;
        bit known;
        opc   = i[6:0];
        known = opc inside {7'h03, 7'h07, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h27, 7'h2F,
                            7'h33, 7'h37, 7'h3B, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53,
                            7'h63, 7'h67, 7'h6F, 7'h73};
        mop = (opc == 7'h33 || opc == 7'h3B) && (i[31:25] == 7'd1);
        ill = (i[1:0] != 2'b11) || !known;
        eb  = !ill && (opc == 7'h73) && (i[31:7] == 25'h0002000);
        st  = opc inside {7'h23, 7'h27};
        mem = st || (opc inside {7'h03, 7'h07, 7'h2F});
        wr  = !(st || opc == 7'h63 || opc == 7'h0F) && (i[11:7] != 5'd0);
    endtask

    function automatic logic [7:0] exp_strobes(input logic [3:0] st);
        return {st == ST_FR, st == ST_MR, (st == ST_MR) && cur_st, (st == ST_WB) && cur_wr,
                (st == ST_WB) || (st == ST_TRAP), st == ST_TRAP, st == ST_TRAP, st == ST_HALT};
    endfunction

    // Called at a falling edge: check the current state's outputs, drive inputs, advance one cycle.
    task automatic step(input logic [3:0] st, input logic irdy, input logic irsp,
                        input logic [31:0] iinst, input logic mrdy, input logic mrsp, input logic exu);
        check("state", state_o, st);
        check("strobes", {ifu_req_valid, lsu_req_valid, lsu_req_we, rf_we, pc_we,
                          pc_sel_trap, trap_valid, halt}, exp_strobes(st));
        ifu_req_ready = irdy;
        ifu_rsp_valid = irsp;
        ifu_rsp_inst  = iinst;
        lsu_req_ready = mrdy;
        lsu_rsp_valid = mrsp;
        exu_done      = exu;
        @(negedge clk);
    endtask

    task automatic noise_step(input logic [3:0] st);
        step(st, rb(), rb(), $urandom, rb(), rb(), rb());
    endtask

    // One bus phase: the awaited handshake arrives after dly idle cycles, unless the timeout hits first.
    task automatic phase(input logic [3:0] st, input int dly, input logic [31:0] inst, output bit got);
        bit hs;
        got = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            hs = (c == dly);
            case (st)
                ST_FR:   step(st, hs, rb(), $urandom, 1'b0, 1'b0, rb());
                ST_FW:   step(st, 1'b0, hs, hs ? inst : $urandom, 1'b0, 1'b0, rb());
                ST_MR:   step(st, 1'b0, 1'b0, $urandom, hs, rb(), rb());
                default: step(st, 1'b0, 1'b0, $urandom, 1'b0, hs, rb());
            endcase
            if (hs) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic trap(input logic [3:0] cause);
        check("trap_cause", trap_cause, cause);
        noise_step(ST_TRAP);
        check("retire_after_trap", retire_cnt, exp_retire);
    endtask

    // res: 0 retired, 1 trapped, 2 halted, 3 abandoned in MEM_WAIT
    task automatic run_inst(input logic [31:0] inst, input int rq, input int rs, input int mq,
                            input int ms, input int ex, input bit abort_mw, output int res);
        bit ill, eb, mem, st, mop, wr, got;
        classify(inst, ill, eb, mem, st, mop, wr);
        cur_st = st;
        cur_wr = wr;
        res = 1;
        phase(ST_FR, rq, inst, got);
        if (!got) begin trap(4'd1); return; end
        phase(ST_FW, rs, inst, got);
        if (!got) begin trap(4'd1); return; end
        check("inst_reg", inst_reg, inst);
        noise_step(ST_DEC);
        if (ill) begin trap(4'd2); return; end
        if (eb) begin
            repeat (4) noise_step(ST_HALT);
            res = 2;
            return;
        end
        if (mop) begin
            for (int k = 0; k <= ex; k++) step(ST_EXEC, rb(), rb(), $urandom, rb(), rb(), k == ex);
        end else begin
            noise_step(ST_EXEC);
        end
        if (mem) begin
            phase(ST_MR, mq, inst, got);
            if (!got) begin trap(st ? 4'd7 : 4'd5); return; end
            if (abort_mw) begin
                step(ST_MW, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
                res = 3;
                return;
            end
            phase(ST_MW, ms, inst, got);
            if (!got) begin trap(st ? 4'd7 : 4'd5); return; end
        end
        noise_step(ST_WB);
        exp_retire = exp_retire + 1;
        check("retire_cnt", retire_cnt, exp_retire);
        res = 0;
    endtask

    // Entered at a falling edge; reset is asserted mid-cycle and a stray lsu_rsp_valid follows release.
    task automatic do_reset();
        rst_n = 1'b0;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'h0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; exu_done = 1'b0;
        exp_retire = '0;
        #1;
        check("rst_state", state_o, ST_IDLE);
        check("rst_strobes", {ifu_req_valid, lsu_req_valid, lsu_req_we, rf_we, pc_we,
                              pc_sel_trap, trap_valid, halt}, 8'h00);
        check("rst_inst_reg", inst_reg, 32'h0);
        check("rst_retire", retire_cnt, exp_retire);
        check("rst_cause", trap_cause, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(ST_IDLE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("post_rst_state", state_o, ST_FR);
        check("post_rst_retire", retire_cnt, exp_retire);
    endtask

    task automatic run(input logic [31:0] inst, input int rq, input int rs, input int mq,
                       input int ms, input int ex, input bit abort_mw);
        int res;
        run_inst(inst, rq, rs, mq, ms, ex, abort_mw, res);
        $display("inst=%08h dly=%0d/%0d/%0d/%0d/%0d res=%0d retired=%0d",
                 inst, rq, rs, mq, ms, ex, res, retire_cnt);
        if (res >= 2) do_reset();
    endtask

    function automatic int rand_dly();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 9)) : int'($urandom_range(0, 2));
    endfunction

    logic [31:0] itab [16] = '{
        32'h00100093, 32'h0020a023, 32'h0000a183, 32'h0000000B,
        32'h022081b3, 32'h00208463, 32'h0000000f, 32'h00000033,
        32'h0020a1af, 32'h123452b7, 32'h00000001, 32'h022081bb,
        32'h0020a027, 32'h00000057, 32'h00100073, 32'h0000707B
    };

    initial begin
        rst_n = 1'b0;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'h0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; exu_done = 1'b0;
        cur_st = 1'b0; cur_wr = 1'b0;
        exp_retire = '0;
        @(negedge clk);
        do_reset();

        run(32'h00100093, 0, 0, 0, 0, 0, 1'b0);            // ADDI x1
        run(32'h0020a023, 0, 0, 3, 0, 0, 1'b0);            // SW, ready after 3 cycles
        run(32'h0000000B, 0, 0, 0, 0, 0, 1'b0);            // CUSTOM_0
        run(32'h00100093, 1000, 0, 0, 0, 0, 1'b0);         // fetch never accepted
        run(32'h022081b3, 0, 0, 0, 0, 4, 1'b0);            // MUL, exu_done in 5th cycle
        run(32'h00100093, TIMEOUT-1, TIMEOUT-1, 0, 0, 0, 1'b0);
        run(32'h0000a183, 0, TIMEOUT, 0, 0, 0, 1'b0);      // fetch response timeout
        run(32'h0000a183, 0, 0, 0, TIMEOUT-1, 0, 1'b0);
        run(32'h0000a183, 0, 0, 0, TIMEOUT, 0, 1'b0);      // load timeout, cause 5
        run(32'h0020a023, 0, 0, TIMEOUT, 0, 0, 1'b0);      // store timeout, cause 7
        run(32'h0020a1af, 0, 0, 0, 20, 0, 1'b0);           // AMO timeout, cause 5
        run(32'h00000001, 0, 0, 0, 0, 0, 1'b0);            // low bits not 11
        run(32'h00000033, 0, 0, 0, 0, 0, 1'b0);            // rd=x0, no rf_we
        run(32'h00100073, 0, 0, 0, 0, 0, 1'b0);            // ebreak
        run(32'h00100093, 0, 0, 0, 0, 0, 1'b0);
        run(32'h0000a183, 0, 0, 0, 0, 0, 1'b1);            // reset during MEM_WAIT

        for (int n = 0; n < 200; n++) begin
            logic [31:0] inst;
            inst = ($urandom_range(0, 9) == 0) ? $urandom : itab[$urandom_range(0, 15)];
            run(inst, rand_dly(), rand_dly(), rand_dly(), rand_dly(), $urandom_range(0, 5), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
